// File: rtl/processor_pkg.sv
// Shared types and constants for the 16-bit processor control path.
package processor_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned PC_W     = 8;

    localparam logic [OPCODE_W-1:0] OP_HALT_DEFAULT = 4'hF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        FAULT  = 3'd6
    } seq_state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Control/strobe bundle between the instruction sequencer and the datapath.
interface instr_sequencer_if
    import processor_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) ();

    logic                run;
    logic                step_mode;
    logic                step_pulse;
    logic [OPCODE_W-1:0] opcode;
    logic                jump_flag;
    logic                regwrite_flag;
    logic                imem_ready;

    logic                imem_req;
    logic                ir_load;
    logic                pc_inc;
    logic                pc_load;
    logic                reg_we;
    logic                halted;
    logic                fault;
    logic [2:0]          state;
    logic [CNT_W-1:0]    instr_count;

    // master = sequencer, slave = datapath / debug host
    modport master (
        input  run, step_mode, step_pulse, opcode, jump_flag, regwrite_flag, imem_ready,
        output imem_req, ir_load, pc_inc, pc_load, reg_we, halted, fault, state, instr_count
    );

    modport slave (
        output run, step_mode, step_pulse, opcode, jump_flag, regwrite_flag, imem_ready,
        input  imem_req, ir_load, pc_inc, pc_load, reg_we, halted, fault, state, instr_count
    );

endinterface

// File: rtl/seq_wait_timer.sv
// Consecutive-wait counter for FETCH; flags the cycle on which the wait limit is hit.
module seq_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LAST    = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam bit          ENABLED = (TIMEOUT != 0);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires on the Nth consecutive enabled cycle, so the count never needs to reach TIMEOUT.
    assign expired = ENABLED && enable && (cnt_q == CW'(LAST));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with run/halt, single-step and imem timeout.
module instr_sequencer
    import processor_pkg::*;
#(
    parameter logic [OPCODE_W-1:0] OP_HALT      = OP_HALT_DEFAULT,
    parameter int unsigned         IMEM_TIMEOUT = 15,
    parameter int unsigned         CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rstn,
    instr_sequencer_if.master bus
);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [CNT_W-1:0] count_q;
    logic             retire;
    logic             wait_en;
    logic             wait_expired;

    assign wait_en = (state_q == FETCH) && !bus.imem_ready;

    seq_wait_timer #(
        .TIMEOUT (IMEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (!wait_en),
        .enable  (wait_en),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        bus.ir_load = 1'b0;
        bus.pc_inc  = 1'b0;
        bus.pc_load = 1'b0;
        bus.reg_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.run && (!bus.step_mode || bus.step_pulse)) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Ready takes priority over a timeout firing in the same cycle.
                if (bus.imem_ready) begin
                    bus.ir_load = 1'b1;
                    state_d     = DECODE;
                end else if (wait_expired) begin
                    state_d = FAULT;
                end
            end
            DECODE: begin
                state_d = (bus.opcode == OP_HALT) ? HALT : EXEC;
            end
            EXEC: begin
                if (bus.jump_flag) begin
                    bus.pc_load = 1'b1;
                end else begin
                    bus.pc_inc = 1'b1;
                end
                if (bus.regwrite_flag) begin
                    state_d = WB;
                end else begin
                    retire = 1'b1;
                end
            end
            WB: begin
                bus.reg_we = 1'b1;
                retire     = 1'b1;
            end
            HALT: begin
                if (!bus.run) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (retire) begin
            state_d = (!bus.run || bus.step_mode) ? IDLE : FETCH;
        end
    end

    assign bus.imem_req    = (state_q == FETCH);
    assign bus.halted      = (state_q == HALT);
    assign bus.fault       = (state_q == FAULT);
    assign bus.state       = state_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed, table-driven bench for instr_sequencer plus hand-written timeout/reset sequences.
module tb_instr_sequencer;

    logic clk;
    logic rstn;

    instr_sequencer_if #(.CNT_W(16)) bus ();

    instr_sequencer #(
        .OP_HALT      (4'hF),
        .IMEM_TIMEOUT (15),
        .CNT_W        (16)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        run;
        logic        step_mode;
        logic        step_pulse;
        logic [3:0]  opcode;
        logic        jump_flag;
        logic        regwrite_flag;
        logic        imem_ready;
        logic [2:0]  st;
        logic [6:0]  strb;   // {imem_req, ir_load, pc_inc, pc_load, reg_we, halted, fault}
        logic [15:0] cnt;
    } vec_t;

    localparam int NVEC = 31;
    vec_t tbl [NVEC];

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic vec_t mk(input logic r, input logic sm, input logic sp,
                                input logic [3:0] op, input logic jf, input logic rw,
                                input logic rdy, input logic [2:0] st,
                                input logic [6:0] strb, input logic [15:0] cnt);
        vec_t v;
        v.run = r; v.step_mode = sm; v.step_pulse = sp; v.opcode = op;
        v.jump_flag = jf; v.regwrite_flag = rw; v.imem_ready = rdy;
        v.st = st; v.strb = strb; v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [25:0] observed();
        return {bus.state, bus.imem_req, bus.ir_load, bus.pc_inc, bus.pc_load,
                bus.reg_we, bus.halted, bus.fault, bus.instr_count};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic sm, input logic sp, input logic [3:0] op,
                         input logic jf, input logic rw, input logic rdy);
        bus.run = r; bus.step_mode = sm; bus.step_pulse = sp; bus.opcode = op;
        bus.jump_flag = jf; bus.regwrite_flag = rw; bus.imem_ready = rdy;
    endtask

    initial begin
        bit found;
        int nfetch;
        bit all_fetch;

        // run, sm, sp, op, jf, rw, rdy | state, strobes, count
        tbl[0]  = mk(1,0,0,4'h0,0,0,1, 3'd0, 7'b0000000, 16'd0);
        tbl[1]  = mk(1,0,0,4'h0,0,0,1, 3'd1, 7'b1100000, 16'd0);
        tbl[2]  = mk(1,0,0,4'h0,0,0,1, 3'd2, 7'b0000000, 16'd0);
        tbl[3]  = mk(1,0,0,4'h0,0,0,1, 3'd3, 7'b0010000, 16'd0);
        tbl[4]  = mk(1,0,0,4'h0,0,1,1, 3'd1, 7'b1100000, 16'd1);
        tbl[5]  = mk(1,0,0,4'h0,0,1,1, 3'd2, 7'b0000000, 16'd1);
        tbl[6]  = mk(1,0,0,4'h0,0,1,1, 3'd3, 7'b0010000, 16'd1);
        tbl[7]  = mk(1,0,0,4'h0,0,1,1, 3'd4, 7'b0000100, 16'd1);
        tbl[8]  = mk(1,0,0,4'h1,1,0,1, 3'd1, 7'b1100000, 16'd2);
        tbl[9]  = mk(1,0,0,4'h1,1,0,1, 3'd2, 7'b0000000, 16'd2);
        tbl[10] = mk(1,0,0,4'h1,1,0,1, 3'd3, 7'b0001000, 16'd2);
        tbl[11] = mk(1,0,0,4'h0,0,0,0, 3'd1, 7'b1000000, 16'd3);
        tbl[12] = mk(1,0,0,4'h0,0,0,0, 3'd1, 7'b1000000, 16'd3);
        tbl[13] = mk(1,0,0,4'h0,0,0,0, 3'd1, 7'b1000000, 16'd3);
        tbl[14] = mk(1,0,0,4'hF,0,0,1, 3'd1, 7'b1100000, 16'd3);
        tbl[15] = mk(1,0,0,4'hF,0,0,1, 3'd2, 7'b0000000, 16'd3);
        tbl[16] = mk(1,0,0,4'hF,0,0,1, 3'd5, 7'b0000010, 16'd3);
        tbl[17] = mk(0,0,0,4'hF,0,0,1, 3'd5, 7'b0000010, 16'd3);
        tbl[18] = mk(0,0,0,4'h0,0,0,1, 3'd0, 7'b0000000, 16'd3);
        tbl[19] = mk(1,1,0,4'h2,0,0,1, 3'd0, 7'b0000000, 16'd3);
        tbl[20] = mk(1,1,1,4'h2,0,0,1, 3'd0, 7'b0000000, 16'd3);
        tbl[21] = mk(1,1,0,4'h2,0,0,1, 3'd1, 7'b1100000, 16'd3);
        tbl[22] = mk(1,1,0,4'h2,0,0,1, 3'd2, 7'b0000000, 16'd3);
        tbl[23] = mk(1,1,0,4'h2,0,0,1, 3'd3, 7'b0010000, 16'd3);
        tbl[24] = mk(1,1,0,4'h2,0,0,1, 3'd0, 7'b0000000, 16'd4);
        tbl[25] = mk(1,0,0,4'h0,0,1,1, 3'd0, 7'b0000000, 16'd4);
        tbl[26] = mk(0,0,0,4'h0,0,1,1, 3'd1, 7'b1100000, 16'd4);
        tbl[27] = mk(0,0,0,4'h0,0,1,1, 3'd2, 7'b0000000, 16'd4);
        tbl[28] = mk(0,0,0,4'h0,0,1,1, 3'd3, 7'b0010000, 16'd4);
        tbl[29] = mk(0,0,0,4'h0,0,1,1, 3'd4, 7'b0000100, 16'd4);
        tbl[30] = mk(0,0,0,4'h0,0,1,1, 3'd0, 7'b0000000, 16'd5);

        drive(0,0,0,4'h0,0,0,0);
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1 check("reset_state", 32'(observed()), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].run, tbl[i].step_mode, tbl[i].step_pulse, tbl[i].opcode,
                  tbl[i].jump_flag, tbl[i].regwrite_flag, tbl[i].imem_ready);
            #1;
            check($sformatf("vec%0d", i), 32'(observed()),
                  32'({tbl[i].st, tbl[i].strb, tbl[i].cnt}));
            @(negedge clk);
        end

        // Asynchronous reset while a writeback is in flight.
        drive(1,0,0,4'h0,0,1,1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            #1;
            if (bus.state == 3'd4) found = 1'b1;
            else @(negedge clk);
        end
        check("wb_reached", 32'(found), 32'd1);
        check("wb_strobe_before_reset", 32'({bus.reg_we, bus.instr_count}), 32'({1'b1, 16'd5}));
        rstn = 1'b0;
        #1 check("reset_in_wb", 32'({bus.state, bus.reg_we, bus.instr_count}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // imem never ready: FAULT after exactly 15 FETCH cycles, then sticky.
        drive(1,0,0,4'h0,0,0,0);
        nfetch = 0;
        found  = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            #1;
            if (bus.state == 3'd1) nfetch++;
            else if (bus.state == 3'd6) found = 1'b1;
        end
        check("fault_entered", 32'(found), 32'd1);
        check("fetch_cycles_to_fault", 32'(nfetch), 32'd15);
        check("fault_outputs", 32'({bus.fault, bus.imem_req, bus.halted}), 32'b100);
        for (int i = 0; i < 4; i++) begin
            bus.run = i[0];
            @(negedge clk);
            #1;
            check($sformatf("fault_sticky%0d", i),
                  32'({bus.state, bus.fault, bus.imem_req, bus.ir_load}), 32'({3'd6, 3'b100}));
        end
        rstn = 1'b0;
        #1 check("fault_cleared_by_reset", 32'({bus.state, bus.fault}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Ready arriving on the 15th wait cycle beats the timeout.
        drive(1,0,0,4'h0,0,0,0);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clk);
            #1;
            if (bus.state == 3'd1) found = 1'b1;
        end
        check("fetch_reached", 32'(found), 32'd1);
        all_fetch = 1'b1;
        for (int k = 1; k < 15; k++) begin
            @(negedge clk);
            #1;
            if (bus.state != 3'd1) all_fetch = 1'b0;
        end
        check("still_fetching_14_waits", 32'(all_fetch), 32'd1);
        bus.imem_ready = 1'b1;
        #1 check("ready_wins_cycle", 32'({bus.state, bus.ir_load, bus.fault}), 32'({3'd1, 2'b10}));
        @(negedge clk);
        #1 check("ready_wins_decode", 32'({bus.state, bus.fault}), 32'({3'd2, 1'b0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle sequencer for the 16-bit custom processor. It drives the fetch/decode/execute/writeback cadence around the PC, instruction ROM, IR, decoder and register file. It issues the PC increment/load, IR load and register write strobes, and handles instruction-memory wait states. It also supports run/halt, single-step debug, an imem timeout fault, and a retired-instruction counter.

Parameters:
OP_HALT, 4'hF, opcode that stops the sequencer in HALT
IMEM_TIMEOUT, 15, max FETCH wait cycles without imem_ready before FAULT; 0 disables the timeout
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
run  input  1  level; 1 = sequencer allowed to issue instructions
step_mode  input  1  1 = single-step debug mode
step_pulse  input  1  in step_mode, releases one instruction from IDLE
opcode  input  4  opcode from decoder (valid from DECODE onward)
jump_flag  input  1  decoder jump/PC-select flag
regwrite_flag  input  1  decoder register-write flag
imem_ready  input  1  instruction memory data valid
imem_req  output  1  fetch request to instruction memory
ir_load  output  1  IR capture strobe
pc_inc  output  1  PC += 1 strobe
pc_load  output  1  PC <= jump address strobe
reg_we  output  1  register file write enable
halted  output  1  sequencer in HALT
fault  output  1  sequencer in FAULT (imem timeout)
state  output  3  current state encoding
instr_count  output  CNT_W  retired instructions

Behaviour:
- Reset (async, rstn=0): state=IDLE, wait_cnt=0, instr_count=0. All strobes, halted and fault are 0.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5, FAULT=6. Encoding 7 is illegal and recovers to IDLE next cycle.
- IDLE: go to FETCH when run=1 and (step_mode=0 or step_pulse=1). Otherwise stay.
- FETCH: imem_req=1.
  - If imem_ready=1: ir_load=1 this cycle (Mealy), wait_cnt cleared, go to DECODE.
  - Else wait_cnt increments. If IMEM_TIMEOUT!=0 and wait_cnt==IMEM_TIMEOUT-1 on a ready=0 cycle, go to FAULT. This means FAULT is entered after exactly IMEM_TIMEOUT consecutive not-ready cycles.
  - If ready arrives on the same cycle the timeout would fire, ready wins.
- DECODE: if opcode==OP_HALT, go to HALT. The PC is not advanced and the instruction is not retired. Otherwise go to EXEC.
- EXEC: exactly one of pc_load (jump_flag=1) or pc_inc (jump_flag=0) is asserted for this single cycle.
  - If regwrite_flag=1, go to WB.
  - Else retire the instruction.
- WB: reg_we=1 for one cycle, then retire.
- Retire, on the leaving edge of EXEC or WB:
  - instr_count += 1, wrapping from all-ones to 0.
  - Next state is IDLE if run=0 or step_mode=1; otherwise FETCH.
- HALT: halted=1, no strobes. Go to IDLE when run=0.
- FAULT: fault=1, no strobes. Sticky; exits only via reset.
- Output decoding:
  - imem_req, halted, fault and state are Moore (decoded from state only).
  - ir_load, pc_inc, pc_load and reg_we are each one cycle wide and never asserted outside their own state.
- Latency, zero wait states: non-writeback instruction = 3 cycles (FETCH, DECODE, EXEC); writeback instruction = 4 cycles. Each imem wait cycle adds one.
- run falling mid-instruction: the current instruction completes, then IDLE. No partial instruction is ever abandoned except by reset.
- step_mode: one instruction per IDLE visit. If step_pulse is held high, one instruction issues every (latency+1) cycles.
- Reset mid-instruction: immediate IDLE. Strobes drop asynchronously.

Decomposition:
- Shared package (processor_pkg): state enum/localparams IDLE..FAULT, OP_HALT default, opcode width 4, PC width 8.
- No sub-module is required. The FETCH wait/timeout counter may be factored into seq_wait_timer (inputs: clear, enable; output: expired), with IMEM_TIMEOUT as its parameter.

Test Plan:
- Reset then run=1, step_mode=0, imem_ready=1 constant, opcodes alternating: non-jump no-write, then write:
  - state sequence 1,2,3,1,2,3,4,1…
  - pc_inc pulses in each EXEC, reg_we only in WB.
  - instr_count=2 after 7 cycles.
- jump_flag=1 in EXEC → pc_load=1 and pc_inc=0 that cycle; instr_count increments by 1.
- imem_ready low 3 cycles then high → FETCH lasts 4 cycles, ir_load exactly on the 4th, no fault.
- imem_ready held 0 with IMEM_TIMEOUT=15 → FAULT after 15 FETCH cycles; fault=1 persists with run toggling; cleared only by rstn=0.
- opcode=4'hF → HALT after DECODE, halted=1, instr_count unchanged, no pc_inc; run=0 → IDLE next cycle.
- step_mode=1, single step_pulse → exactly one instruction then IDLE, instr_count+1.
- rstn asserted during WB → state=0, reg_we=0 immediately, instr_count=0.
